// File: rtl/display_7s_arbiter_if.sv
// rtl/display_7s_arbiter_if.sv - requester bundle and display_7s drive signals of the arbiter
interface display_7s_arbiter_if;
  logic [3:0]   req;
  logic [255:0] req_data;
  logic [31:0]  req_mode;
  logic [31:0]  req_blink;
  logic [3:0]   grant;
  logic [1:0]   owner;
  logic         busy;
  logic         dis_en;
  logic [63:0]  dis_data;
  logic [7:0]   dis_mode;
  logic [7:0]   dis_blink;

  modport master (
    output req, req_data, req_mode, req_blink,
    input  grant, owner, busy, dis_en, dis_data, dis_mode, dis_blink
  );

  modport slave (
    input  req, req_data, req_mode, req_blink,
    output grant, owner, busy, dis_en, dis_data, dis_mode, dis_blink
  );
endinterface

// File: rtl/display_7s_arbiter.sv
// rtl/display_7s_arbiter.sv - round-robin owner of the display_7s driver with minimum hold time
module display_7s_arbiter #(
  parameter int unsigned PRESCALER_RLD          = 99_999,
  parameter int unsigned PRESCALER_RLD_TURBOSIM = 9,
  parameter int unsigned HOLD_RLD               = 999,
  parameter int unsigned HOLD_RLD_TURBOSIM      = 4
) (
  input logic                 clk,
  input logic                 reset_n,
  input logic                 turbosim,
  display_7s_arbiter_if.slave bus
);
  localparam int PW = $clog2(PRESCALER_RLD + 1);
  localparam int HW = $clog2(HOLD_RLD + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_OWN    = 2'd1;
  localparam logic [1:0] S_SWITCH = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    grant_q, grant_d;
  logic [1:0]    owner_q, owner_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          dis_en_q, dis_en_d;
  logic [63:0]   dis_data_q, dis_data_d;
  logic [7:0]    dis_mode_q, dis_mode_d;
  logic [7:0]    dis_blink_q, dis_blink_d;

  logic [PW-1:0] presc_rld;
  logic [HW-1:0] hold_rld;
  logic [1:0]    pick;
  logic [1:0]    cand;
  logic          found;

  assign presc_rld = turbosim ? PW'(PRESCALER_RLD_TURBOSIM) : PW'(PRESCALER_RLD);
  assign hold_rld  = turbosim ? HW'(HOLD_RLD_TURBOSIM) : HW'(HOLD_RLD);

  // Search starts just after the current owner, so the owner itself ranks last.
  always_comb begin
    pick  = owner_q;
    cand  = owner_q;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = owner_q + 2'(i);
      if (!found && bus.req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    presc_d = presc_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE, S_SWITCH: begin
        grant_d = 4'b0000;
        state_d = S_IDLE;
        if (|bus.req) begin
          state_d = S_OWN;
          owner_d = pick;
          grant_d = 4'b0001 << pick;
          presc_d = presc_rld;
          hold_d  = hold_rld;
        end
      end
      S_OWN: begin
        if (presc_q == '0) begin
          presc_d = presc_rld;
          if (hold_q != '0) hold_d = hold_q - HW'(1);
        end else begin
          presc_d = presc_q - PW'(1);
        end
        if (!bus.req[owner_q] || (hold_q == '0 && |(bus.req & ~grant_q))) begin
          state_d = S_SWITCH;
          grant_d = 4'b0000;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  // Payload is re-sampled every owned cycle so requester updates reach the display live.
  always_comb begin
    dis_en_d    = (state_q == S_OWN);
    dis_data_d  = '0;
    dis_mode_d  = '0;
    dis_blink_d = '0;
    if (state_q == S_OWN) begin
      dis_data_d  = bus.req_data[{owner_q, 6'd0} +: 64];
      dis_mode_d  = bus.req_mode[{owner_q, 3'd0} +: 8];
      dis_blink_d = bus.req_blink[{owner_q, 3'd0} +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      owner_q     <= 2'd3;
      presc_q     <= '0;
      hold_q      <= '0;
      dis_en_q    <= 1'b0;
      dis_data_q  <= '0;
      dis_mode_q  <= '0;
      dis_blink_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      presc_q     <= presc_d;
      hold_q      <= hold_d;
      dis_en_q    <= dis_en_d;
      dis_data_q  <= dis_data_d;
      dis_mode_q  <= dis_mode_d;
      dis_blink_q <= dis_blink_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.dis_en    = dis_en_q;
  assign bus.dis_data  = dis_data_q;
  assign bus.dis_mode  = dis_mode_q;
  assign bus.dis_blink = dis_blink_q;
endmodule
